regfile_wb_arbiter: RTL

Write-port arbiter and scoreboard for the single-write-port, write-on-negedge integer/FP register file. It shares the A3/D3/WE3 port between the in-order pipeline writeback stage and a long-latency unit (FPU/divider) using a small result FIFO. It tracks destination registers with outstanding long-latency results so the hazard unit can stall dependent instructions. It also raises a stall request when the long-latency path is starved.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/regfile_wb_fifo.sv | 50 +++++
 rtl/regfile_wb_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared register-file constants and the writeback request bundle.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Synchronous FIFO of {rd, data} long-latency results; head is visible the cycle after push.
// Caller guarantees no push when full; push and pop may coincide.
module regfile_wb_fifo #(
  parameter int ADDR_W = 5,
  parameter int XLEN   = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_rd,
  input  logic [XLEN-1:0]            push_data,
  input  logic                       pop,
  output logic [ADDR_W-1:0]          head_rd,
  output logic [XLEN-1:0]            head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0]   data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the RF write port between pipeline writeback (priority) and buffered long-latency results.
// Write port is combinational; lu_ready drops when the result FIFO is full; stall_req flags starvation.
module regfile_wb_arbiter #(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int ADDR_W   = riscv_pkg::REG_ADDR_W,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]   lu_data,
  output logic              lu_ready,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] q_rs1,
  input  logic [ADDR_W-1:0] q_rs2,
  input  logic [ADDR_W-1:0] q_rd,
  output logic              busy_rs1,
  output logic              busy_rs2,
  output logic              busy_rd,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [XLEN-1:0]   rf_d3,
  output logic              stall_req
);

  import riscv_pkg::*;

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int WW   = $clog2(MAX_WAIT + 1);
  localparam int NREG = 2 ** ADDR_W;

  logic [CW-1:0]     fifo_count;
  logic [ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]   head_data;
  logic              fifo_ne;
  logic              fifo_push;
  logic              fifo_pop;
  logic              bypass;
  logic              lu_accept;
  wb_req_t           wr;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_nxt;
  logic [WW-1:0]     wait_cnt;

  regfile_wb_fifo #(
    .ADDR_W (ADDR_W),
    .XLEN   (XLEN),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_rd   (lu_rd),
    .push_data (lu_data),
    .pop       (fifo_pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (fifo_count)
  );

  assign fifo_ne   = (fifo_count != '0);
  assign lu_ready  = rst && (fifo_count < CW'(DEPTH));
  assign lu_accept = lu_valid && lu_ready;

  always_comb begin
    wr       = '0;
    fifo_pop = 1'b0;
    bypass   = 1'b0;
    if (rst) begin
      if (wb_valid && wb_rd != REG_ZERO) begin
        wr = '{valid: 1'b1, rd: wb_rd, data: wb_data};
      end else if (fifo_ne) begin
        wr       = '{valid: 1'b1, rd: head_rd, data: head_data};
        fifo_pop = 1'b1;
      end else if (lu_accept && lu_rd != REG_ZERO) begin
        wr     = '{valid: 1'b1, rd: lu_rd, data: lu_data};
        bypass = 1'b1;
      end
    end
  end

  // x0 results are acknowledged but never stored.
  assign fifo_push = lu_accept && (lu_rd != REG_ZERO) && !bypass;

  assign rf_we = wr.valid;
  assign rf_a3 = wr.rd;
  assign rf_d3 = wr.data;

  // Issue after clear so a same-cycle re-issue keeps the register pending.
  always_comb begin
    busy_nxt = busy_q;
    if (fifo_pop || bypass) busy_nxt[wr.rd] = 1'b0;
    if (iss_valid && iss_rd != REG_ZERO) busy_nxt[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_nxt;
  end

  assign busy_rs1 = rst && busy_q[q_rs1];
  assign busy_rs2 = rst && busy_q[q_rs2];
  assign busy_rd  = rst && busy_q[q_rd];

  // A non-empty FIFO that is not popping is, by priority, blocked by wb.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!fifo_ne || fifo_pop) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WW'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  assign stall_req = rst && (wait_cnt == WW'(MAX_WAIT));

endmodule
